// File: rtl/fixed_addsub_pipe.sv
// rtl/fixed_addsub_pipe.sv - two-stage signed fixed-point add/sub with saturation and overflow tracking
module fixed_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 8,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub_n_add,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             ovf_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  if (FRAC < 0 || FRAC > WIDTH) begin : g_frac_range
    $error("FRAC must lie within 0..WIDTH");
  end

  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_wide;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_res;
  logic             r_s2_ovf;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_wide;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_s2_ready;
  logic             w_in_ready;
  logic             w_out_xfer;

  assign w_a_ext = {a_in[WIDTH-1], a_in};
  assign w_b_ext = {b_in[WIDTH-1], b_in};
  assign w_wide  = sub_n_add ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

  // Sign and top result bit disagree exactly when the true value left the WIDTH-bit range.
  assign w_ovf = r_s1_wide[WIDTH] ^ r_s1_wide[WIDTH-1];

  always_comb begin
    w_res = r_s1_wide[WIDTH-1:0];
    if (w_ovf && (SAT_EN != 0)) begin
      w_res = r_s1_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_wide  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_ovf   <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_wide <= w_wide;
        end
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_res <= w_res;
          r_s2_ovf <= w_ovf;
        end
      end
    end
  end

  // A clear coinciding with an overflowed transfer counts that transfer as the first event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (w_out_xfer && r_s2_ovf) begin
      r_sticky <= 1'b1;
      if (ovf_clr) begin
        r_count <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!(&r_count)) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (ovf_clr) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_s2_valid;
  assign res_out    = r_s2_res;
  assign ovf_out    = r_s2_ovf;
  assign ovf_sticky = r_sticky;
  assign ovf_count  = r_count;

endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// tb/tb_fixed_addsub_pipe.sv - scoreboard bench for fixed_addsub_pipe, saturating and wrapping builds
module tb_fixed_addsub_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_in, b_in;
  logic        sub_n_add, in_valid, out_ready, ovf_clr;

  logic        in_ready1, out_valid1, ovf_out1, ovf_sticky1;
  logic [31:0] res_out1;
  logic [15:0] ovf_count1;
  logic        in_ready2, out_valid2, ovf_out2, ovf_sticky2;
  logic [31:0] res_out2;
  logic [15:0] ovf_count2;

  exp_t q_sat[$];
  exp_t q_wrap[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fixed_addsub_pipe #(.WIDTH(32), .FRAC(8), .SAT_EN(1), .CNT_W(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .sub_n_add(sub_n_add),
    .in_valid(in_valid), .in_ready(in_ready1), .res_out(res_out1), .ovf_out(ovf_out1),
    .out_valid(out_valid1), .out_ready(out_ready), .ovf_sticky(ovf_sticky1),
    .ovf_count(ovf_count1), .ovf_clr(ovf_clr)
  );

  fixed_addsub_pipe #(.WIDTH(32), .FRAC(8), .SAT_EN(0), .CNT_W(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .sub_n_add(sub_n_add),
    .in_valid(in_valid), .in_ready(in_ready2), .res_out(res_out2), .ovf_out(ovf_out2),
    .out_valid(out_valid2), .out_ready(out_ready), .ovf_sticky(ovf_sticky2),
    .ovf_count(ovf_count2), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any result about to transfer is matched against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_ready) begin
      if (out_valid1) begin
        if (q_sat.size() == 0) chk("sat_unexpected_output", 64'(res_out1), 64'hDEAD_0000_0000);
        else begin
          e = q_sat.pop_front();
          chk("sat_res", 64'(res_out1), 64'(e.res));
          chk("sat_ovf", 64'(ovf_out1), 64'(e.ovf));
        end
      end
      if (out_valid2) begin
        if (q_wrap.size() == 0) chk("wrap_unexpected_output", 64'(res_out2), 64'hDEAD_0000_0000);
        else begin
          e = q_wrap.pop_front();
          chk("wrap_res", 64'(res_out2), 64'(e.res));
          chk("wrap_ovf", 64'(ovf_out2), 64'(e.ovf));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [31:0] exp_sat, input logic exp_ovf, input logic [31:0] exp_wrap);
    int n = 0;
    a_in = a; b_in = b; sub_n_add = op; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready1) chk("send_timeout_in_ready", 64'(in_ready1), 64'd1);
    else begin
      q_sat.push_back('{res: exp_sat, ovf: exp_ovf});
      q_wrap.push_back('{res: exp_wrap, ovf: exp_ovf});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_sat.size() != 0 || q_wrap.size() != 0) && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("drain_pending", 64'(q_sat.size() + q_wrap.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; a_in = '0; b_in = '0; sub_n_add = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_res_out", 64'(res_out1), 64'd0);
    chk("rst_ovf_out", 64'(ovf_out1), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky1), 64'd0);
    chk("rst_count", 64'(ovf_count1), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h0000_0180, 32'h0000_0080, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0200);
    send(32'h7FFF_FF00, 32'h0000_0200, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h8000_0100);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF);
    send(32'h0000_0100, 32'h0000_0300, 1'b1, 32'hFFFF_FE00, 1'b0, 32'hFFFF_FE00);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 32'h0000_0000);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000);
    send(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
    drain();
    chk("count_after_vectors", 64'(ovf_count1), 64'd4);
    chk("sticky_after_vectors", 64'(ovf_sticky1), 64'd1);

    // Backpressure: only two operands fit before in_ready drops; head result must hold.
    out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 32'h0000_0003);
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 32'h0000_0030);
        send(32'h0000_0050, 32'h0000_0060, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'hFFFF_FFF0);
        send(32'h0000_1000, 32'h0000_1000, 1'b0, 32'h0000_2000, 1'b0, 32'h0000_2000);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready1), 64'd0);
        chk("bp_out_valid", 64'(out_valid1), 64'd1);
        chk("bp_res_hold0", 64'(res_out1), 64'h3);
        @(negedge clk);
        chk("bp_res_hold1", 64'(res_out1), 64'h3);
        chk("bp_in_ready_still_low", 64'(in_ready1), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    pulse_clr();
    chk("clr_count", 64'(ovf_count1), 64'd0);
    chk("clr_sticky", 64'(ovf_sticky1), 64'd0);

    for (int i = 0; i < 32'hFFFF; i++)
      send(32'h7FFF_FF00, 32'h0000_0200, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h8000_0100);
    drain();
    chk("count_at_max", 64'(ovf_count1), 64'hFFFF);
    send(32'h7FFF_FF00, 32'h0000_0200, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h8000_0100);
    drain();
    chk("count_saturated", 64'(ovf_count1), 64'hFFFF);
    chk("sticky_saturated", 64'(ovf_sticky1), 64'd1);

    // Clear landing on the same edge as an overflowed transfer.
    out_ready = 1'b0;
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF);
    n = 0;
    @(negedge clk);
    while (!out_valid1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("clr_xfer_out_valid", 64'(out_valid1), 64'd1);
    @(posedge clk);
    #1 ovf_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    chk("clr_xfer_count", 64'(ovf_count1), 64'd1);
    chk("clr_xfer_sticky", 64'(ovf_sticky1), 64'd1);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 1'b0, 32'h0000_000B);
    send(32'h7FFF_FF00, 32'h0000_0200, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h8000_0100);
    chk("full_in_ready", 64'(in_ready1), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid1), 64'd0);
    chk("midrst_in_ready", 64'(in_ready1), 64'd1);
    chk("midrst_res_out", 64'(res_out1), 64'd0);
    chk("midrst_count", 64'(ovf_count1), 64'd0);
    chk("midrst_sticky", 64'(ovf_sticky1), 64'd0);
    q_sat.delete();
    q_wrap.delete();
    out_ready = 1'b1;
    #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("postrst_out_valid", 64'(out_valid1), 64'd0);
    @(posedge clk);
    #1;
    send(32'h0000_0180, 32'h0000_0080, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
